// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op bit indices, FSM states, width.
package md_unit_pkg;

  localparam int unsigned MD_DATA_W = 32;
  localparam int unsigned MD_OP_W   = 6;

  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MTHI  = 4;
  localparam int unsigned MD_MTLO  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } md_state_t;

  function automatic logic md_op_onehot(input logic [MD_OP_W-1:0] op);
    return (op != '0) && ((op & (op - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One radix-2 step of the shared multiply (shift-add) / divide (restoring) datapath.
module md_iter_core
  import md_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     operand,
  output logic [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0] mul_upper;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_upper = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    shifted   = acc[2*DATA_W-1:DATA_W-1];
    diff      = shifted - {1'b0, operand};
    acc_next  = {mul_upper, acc[DATA_W-1:1]};
    if (is_div) begin
      if (!diff[DATA_W]) acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else               acc_next = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO; stalls EX via md_busy while iterating.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 md_valid,
  input  logic [MD_OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0]    md_src1,
  input  logic [DATA_W-1:0]    md_src2,
  input  logic                 flush,
  output logic                 md_busy,
  output logic                 md_done,
  output logic [DATA_W-1:0]    hi,
  output logic [DATA_W-1:0]    lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  md_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*DATA_W-1:0]  acc, acc_next, result;
  logic [DATA_W-1:0]    operand, src1_raw;
  logic                 is_div, is_signed, s1, s2, div_zero;
  logic                 accept, iter_start, signed_op;
  logic [DATA_W-1:0]    abs1, abs2, quo, rem;

  assign accept     = md_valid && (state == IDLE) && !flush && md_op_onehot(md_op);
  assign iter_start = accept && (md_op[MD_MULT] | md_op[MD_MULTU] | md_op[MD_DIV] | md_op[MD_DIVU]);
  assign signed_op  = md_op[MD_MULT] | md_op[MD_DIV];
  assign abs1       = (signed_op && md_src1[DATA_W-1]) ? -md_src1 : md_src1;
  assign abs2       = (signed_op && md_src2[DATA_W-1]) ? -md_src2 : md_src2;

  md_iter_core #(.DATA_W(DATA_W)) u_core (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (iter_start) state_next = CALC;
      CALC:    if (flush) state_next = IDLE;
               else if (cnt == CNT_W'(DATA_W - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state == CALC) || (state == FINISH);
    md_done = (state == FINISH);
  end

  // Sign correction of the unsigned magnitude result; divide-by-zero overrides both halves.
  always_comb begin
    quo = acc[DATA_W-1:0];
    rem = acc[2*DATA_W-1:DATA_W];
    if (is_div) begin
      if (is_signed && (s1 ^ s2)) quo = -quo;
      if (is_signed && s1)        rem = -rem;
      if (div_zero) begin
        quo = '1;
        rem = src1_raw;
      end
      result = {rem, quo};
    end else begin
      result = (is_signed && (s1 ^ s2)) ? -acc : acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      operand   <= '0;
      src1_raw  <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      if (accept && md_op[MD_MTHI]) hi <= md_src1;
      if (accept && md_op[MD_MTLO]) lo <= md_src1;
      if (iter_start) begin
        is_div    <= md_op[MD_DIV] | md_op[MD_DIVU];
        is_signed <= signed_op;
        s1        <= signed_op & md_src1[DATA_W-1];
        s2        <= signed_op & md_src2[DATA_W-1];
        div_zero  <= (md_src2 == '0);
        src1_raw  <= md_src1;
        cnt       <= '0;
        if (md_op[MD_DIV] | md_op[MD_DIVU]) begin
          acc     <= {{DATA_W{1'b0}}, abs1};
          operand <= abs2;
        end else begin
          acc     <= {{DATA_W{1'b0}}, abs2};
          operand <= abs1;
        end
      end
      if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FINISH) {hi, lo} <= result;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected {hi,lo}, monitor checks on md_done.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int unsigned W = MD_DATA_W;
  localparam logic [5:0] OP_MULT  = 6'(1 << MD_MULT);
  localparam logic [5:0] OP_MULTU = 6'(1 << MD_MULTU);
  localparam logic [5:0] OP_DIV   = 6'(1 << MD_DIV);
  localparam logic [5:0] OP_DIVU  = 6'(1 << MD_DIVU);
  localparam logic [5:0] OP_MTHI  = 6'(1 << MD_MTHI);
  localparam logic [5:0] OP_MTLO  = 6'(1 << MD_MTLO);

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         md_valid = 1'b0;
  logic [5:0]   md_op = '0;
  logic [W-1:0] md_src1 = '0;
  logic [W-1:0] md_src2 = '0;
  logic         flush = 1'b0;
  logic         md_busy, md_done;
  logic [W-1:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [63:0] sb_q[$];

  md_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .md_valid (md_valid),
    .md_op    (md_op),
    .md_src1  (md_src1),
    .md_src2  (md_src2),
    .flush    (flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every md_done pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (md_done) begin
        done_cnt++;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) check("unexpected md_done", {hi, lo}, 64'h0);
        else                  check("result hi:lo", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fl);
    @(negedge clk);
    md_valid = 1'b1;
    md_op    = op;
    md_src1  = a;
    md_src2  = b;
    flush    = fl;
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op    = '0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!md_busy) break;
      cycles++;
    end
    check(name, 64'(cycles), 64'(exp_cycles));
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    sb_q.push_back({eh, el});
    drive(op, a, b, 1'b0);
    wait_idle(name, 33);
  endtask

  initial begin
    int saved_done;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi:lo", {hi, lo}, 64'h0);
    check("reset busy/done", {62'h0, md_busy, md_done}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    drive(OP_MTHI, 32'hBEEF, 32'h0, 1'b1);
    check("flush blocks MTHI", {hi, lo}, 64'h0);

    run_op("busy MULT -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("busy MULTU max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("busy MULTU carry", OP_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
    run_op("busy DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("busy DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("busy DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("busy DIVU 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("busy DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("busy DIV -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    md_valid = 1'b1; md_op = OP_MTHI; md_src1 = 32'h1234;
    @(posedge clk); #1;
    check("MTHI hi", {32'h0, hi}, 64'h1234);
    check("MTHI busy", {63'h0, md_busy}, 64'h0);
    @(negedge clk);
    md_op = OP_MTLO; md_src1 = 32'h5678;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = '0;
    check("MTLO hi:lo", {hi, lo}, {32'h1234, 32'h5678});
    check("MTLO busy/done", {62'h0, md_busy, md_done}, 64'h0);

    // Flush mid-CALC: abort, HI/LO kept, no md_done.
    saved_done = done_cnt;
    drive(OP_MULT, 32'd5, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush idle", {63'h0, md_busy}, 64'h0);
    repeat (40) @(negedge clk);
    check("flush hi:lo", {hi, lo}, {32'h1234, 32'h5678});
    check("flush no done", 64'(done_cnt), 64'(saved_done));

    // Reset mid-CALC: HI/LO cleared, idle.
    drive(OP_MULTU, 32'd9, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("reset mid hi:lo", {hi, lo}, 64'h0);
    check("reset mid busy", {63'h0, md_busy}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("reset mid no done", 64'(done_cnt), 64'(saved_done));

    // Non-one-hot op ignored.
    drive(6'b000011, 32'd3, 32'd4, 1'b0);
    check("bad op busy", {63'h0, md_busy}, 64'h0);
    drive(6'b110000, 32'hAAAA, 32'd4, 1'b0);
    check("bad op hi:lo", {hi, lo}, 64'h0);

    // md_valid while busy is ignored.
    sb_q.push_back({32'h0, 32'd42});
    drive(OP_MULTU, 32'd7, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    md_valid = 1'b1; md_op = OP_MTHI; md_src1 = 32'hDEAD;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = '0;
    wait_idle("busy ignore", 28);

    check("scoreboard drained", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
